timer_mc: RTL

TIMER_MC -- requirements
Module: timer_mc

---
 rtl/timer_mc.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/timer_mc.sv
// Multi-channel prescaled countdown timer with W1C status, level irq and byte-reversed register bus.
// Optional 64-bit free-running mtime at addresses 0/1 when TIMER_MC_MTIME_EN is defined.

module timer_mc_chan (
   input  logic        clk,
   input  logic        rst,
   input  logic        tick,
   input  logic [31:0] wdata,
   input  logic        ctrl_we,
   input  logic        load_we,
   output logic [2:0]  ctrl,
   output logic [31:0] load,
   output logic [31:0] count,
   output logic        fire
);
   // Expiry is seen on the tick that finds COUNT already at zero.
   assign fire = tick && ctrl[0] && (count == 32'd0);

   always_ff @(posedge clk) begin
      if (rst) begin
         ctrl  <= 3'd0;
         load  <= 32'd0;
         count <= 32'd0;
      end else begin
         if (tick && ctrl[0]) begin
            if (count != 32'd0)
               count <= count - 32'd1;
            else if (ctrl[1])
               count <= load;
            else
               ctrl[0] <= 1'b0;
         end
         // Bus writes override the automatic updates above.
         if (ctrl_we)
            ctrl <= wdata[2:0];
         if (load_we) begin
            load  <= wdata;
            count <= wdata;
         end
      end
   end
endmodule

module timer_mc #(
   parameter int          CHANNELS       = 2,
   parameter int unsigned PRESCALE_RESET = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  a,
   input  logic [31:0] d,
   input  logic        we,
   output logic [31:0] spo,
   output logic        irq
);
   function automatic logic [31:0] brev(input logic [31:0] x);
      return {x[7:0], x[15:8], x[23:16], x[31:24]};
   endfunction

   logic [31:0]                wdata;
   logic [31:0]                rdata;
   logic [15:0]                prescale;
   logic [15:0]                pcnt;
   logic                       pre_we;
   logic                       sts_we;
   logic                       tick;
   logic [CHANNELS-1:0]        pending;
   logic [CHANNELS-1:0]        fire;
   logic [CHANNELS-1:0]        ie;
   logic [CHANNELS-1:0][2:0]   ctrl;
   logic [CHANNELS-1:0][31:0]  load;
   logic [CHANNELS-1:0][31:0]  count;

   assign wdata  = brev(d);
   assign pre_we = we && (a == 4'd2);
   assign sts_we = we && (a == 4'd3);
   assign tick   = !pre_we && (pcnt == prescale);

   always_ff @(posedge clk) begin
      if (rst) begin
         prescale <= 16'(PRESCALE_RESET);
         pcnt     <= 16'd0;
      end else if (pre_we) begin
         prescale <= wdata[15:0];
         pcnt     <= 16'd0;
      end else if (pcnt == prescale) begin
         pcnt <= 16'd0;
      end else begin
         pcnt <= pcnt + 16'd1;
      end
   end

   // Set beats clear when both hit the same bit in one cycle.
   always_ff @(posedge clk) begin
      if (rst)
         pending <= '0;
      else
         pending <= (pending & ~(sts_we ? wdata[CHANNELS-1:0] : '0)) | fire;
   end

   for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
      localparam logic [3:0] BASE = 4'(4 + 3 * c);
      timer_mc_chan u_chan (
         .clk     (clk),
         .rst     (rst),
         .tick    (tick),
         .wdata   (wdata),
         .ctrl_we (we && (a == BASE)),
         .load_we (we && (a == BASE + 4'd1)),
         .ctrl    (ctrl[c]),
         .load    (load[c]),
         .count   (count[c]),
         .fire    (fire[c])
      );
      assign ie[c] = ctrl[c][2];
   end

   assign irq = |(pending & ie);

`ifdef TIMER_MC_MTIME_EN
   logic [63:0] mtime;

   always_ff @(posedge clk) begin
      if (rst)
         mtime <= 64'd0;
      else
         mtime <= mtime + 64'd1;
   end
`endif

   always_comb begin
      rdata = 32'd0;
      case (a)
`ifdef TIMER_MC_MTIME_EN
         4'd0:    rdata = mtime[31:0];
         4'd1:    rdata = mtime[63:32];
`endif
         4'd2:    rdata = {16'd0, prescale};
         4'd3:    rdata = 32'(pending);
         default: rdata = 32'd0;
      endcase
      for (int c = 0; c < CHANNELS; c++) begin
         if (a == 4'(4 + 3 * c))     rdata = {29'd0, ctrl[c]};
         if (a == 4'(5 + 3 * c))     rdata = load[c];
         if (a == 4'(6 + 3 * c))     rdata = count[c];
      end
   end

   assign spo = brev(rdata);
endmodule
